// File: rtl/mux_sync_rr.sv
// mux_sync_rr: brings NCH asynchronous toggle-handshake data channels into the
// clk domain. Each channel has a request synchronizer, a hold register and a
// returned acknowledge toggle. Held words leave through one valid/ready port
// under round-robin arbitration.
// Optional feature macro: MUX_SYNC_RR_OVF_EN adds sticky per-channel overflow
// flags (ovf) and their clear input (ovf_clr).
module mux_sync_rr #(
    parameter int DSIZE       = 32,
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2,
    localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*DSIZE-1:0] src_data,
    input  logic [NCH-1:0]       src_req_tgl,
    output logic [NCH-1:0]       src_ack_tgl,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DSIZE-1:0]     out_data,
    output logic [CH_W-1:0]      out_ch
`ifdef MUX_SYNC_RR_OVF_EN
    ,
    output logic [NCH-1:0]       ovf,
    input  logic                 ovf_clr
`endif
);

    // Request synchronizer chains; bit SYNC_STAGES-1 is the synchronized toggle.
    logic [SYNC_STAGES-1:0] r_sync [NCH];
    // Last consumed toggle value per channel; doubles as the ack toggle.
    logic [NCH-1:0]         r_seen;
    // Hold-valid flags and the held words.
    logic [NCH-1:0]         r_hv;
    logic [DSIZE-1:0]       r_hold [NCH];
    // Round-robin start pointer.
    logic [CH_W-1:0]        r_rr;

    logic [NCH-1:0]         w_s;
    logic [NCH-1:0]         w_event;
    logic [NCH-1:0]         w_cap;
    logic [NCH-1:0]         w_pop_vec;
    logic                   w_pop;
    logic [CH_W-1:0]        w_sel;
    logic [CH_W-1:0]        w_rr_next;

    // First channel with a held word, scanning from rr upward with wrap.
    function automatic logic [CH_W-1:0] rr_pick(input logic [NCH-1:0] hv,
                                                input logic [CH_W-1:0] rr);
        logic [CH_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            idx = (int'(rr) + i) % NCH;
            if (!found && hv[idx]) begin
                pick  = CH_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Synchronized request, pending event and pop/capture decode per channel.
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_s       = '0;
        w_pop_vec = '0;
        for (int c = 0; c < NCH; c++) begin
            w_s[c]       = r_sync[c][SYNC_STAGES-1];
            w_pop_vec[c] = w_pop && (w_sel == CH_W'(c));
        end
        w_event = w_s ^ r_seen;
        // A full channel may still capture when its word leaves in this cycle.
        w_cap   = w_event & (~r_hv | w_pop_vec);
    end

    // Output selection is purely combinational from the registered state.
    always_comb begin
        w_sel     = rr_pick(r_hv, r_rr);
        out_valid = |r_hv;
        out_ch    = out_valid ? w_sel : '0;
        out_data  = out_valid ? r_hold[w_sel] : '0;
        w_pop     = out_valid && out_ready;
        w_rr_next = CH_W'((int'(w_sel) + 1) % NCH);
    end

    assign src_ack_tgl = r_seen;

    // Shift each request toggle through its synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                r_sync[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                r_sync[c] <= {r_sync[c][SYNC_STAGES-2:0], src_req_tgl[c]};
            end
        end
    end

    // Capture into the hold registers, track hold-valid and the consumed toggle.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the hold registers are reset too, so out_data is a defined 0
        // after reset and a discarded word can never reappear.
        if (rst) begin
            r_seen <= '0;
            r_hv   <= '0;
            for (int c = 0; c < NCH; c++) begin
                r_hold[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (w_cap[c]) begin
                    r_hold[c] <= src_data[c*DSIZE +: DSIZE];
                    r_hv[c]   <= 1'b1;
                    r_seen[c] <= w_s[c];
                end else if (w_pop_vec[c]) begin
                    r_hv[c]   <= 1'b0;
                end
            end
        end
    end

    // Advance the round-robin pointer past the channel just popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr <= '0;
        end else if (w_pop) begin
            r_rr <= w_rr_next;
        end
    end

`ifdef MUX_SYNC_RR_OVF_EN
    logic [NCH-1:0] r_sp;
    logic [NCH-1:0] r_ovf;
    logic [NCH-1:0] w_ovf_set;

    // A second change of the synchronized toggle while the first is still
    // unconsumed means a transfer was lost.
    assign w_ovf_set = (w_s ^ r_sp) & (r_sp ^ r_seen);
    assign ovf       = r_ovf;

    // Delayed synchronized toggle and sticky overflow flags; set beats clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp  <= '0;
            r_ovf <= '0;
        end else begin
            r_sp  <= w_s;
            r_ovf <= (ovf_clr ? '0 : r_ovf) | w_ovf_set;
        end
    end
`endif

endmodule

// File: doc/mux_sync_rr.md
# mux_sync_rr

Multi-channel mux-recirculation synchronizer with toggle handshake and round-robin output. It brings NCH independent data buses from asynchronous source domains into the `clk` domain. Each channel crosses on a toggle request, with a per-channel hold register and a returned acknowledge toggle. Captured words leave through one valid/ready port under round-robin arbitration. The block sits at the destination side of multi-source CDC paths.

## Interface
Parameters:
- `DSIZE`, 32, data width per channel.
- `NCH`, 4, channel count (≥1).
- `SYNC_STAGES`, 2, flops in each request synchronizer chain (≥2).
- `CH_W` (localparam), max(1, clog2(NCH)), channel index width.

Ports:
- `clk`  in  1  destination clock; single clock for the whole block.
- `rst`  in  1  asynchronous, active-high reset.
- `src_data`  in  NCH*DSIZE  channel c occupies bits [c*DSIZE +: DSIZE]; must be stable from its request toggle until ack is seen.
- `src_req_tgl`  in  NCH  per-channel request toggle, asynchronous to `clk`.
- `src_ack_tgl`  out  NCH  per-channel acknowledge toggle, registered in the `clk` domain.
- `out_valid`  out  1  a captured word is presented.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  DSIZE  presented word.
- `out_ch`  out  CH_W  channel of presented word.
- `ovf`  out  NCH  sticky overflow flags (only with `MUX_SYNC_RR_OVF_EN`).
- `ovf_clr`  in  1  clears all `ovf` (only with `MUX_SYNC_RR_OVF_EN`).

## Operation
Per-channel state:
- `sync[c]`: chain of SYNC_STAGES flops; `s` is the last stage.
- `sp`: `s` delayed one cycle.
- `seen[c]`: last consumed toggle value.
- `hold[c]`: DSIZE-bit data register.
- `hv[c]`: hold-valid flag.
- Reset value of all of the above: 0.

Capture:
- Channel event: `s != seen`.
- Capture when the event is active and either `hv=0` or the channel is popped this cycle.
- On capture:
  - `hold <= src_data slice`
  - `hv <= 1`
  - `seen <= s`
- Without a capture the event stays pending, giving backpressure to the source through the withheld ack.

Acknowledge and output:
- `src_ack_tgl[c] = seen[c]`, so ack toggles on the capture edge.
- Arbiter: `rr` pointer (CH_W bits, reset 0).
- `out_valid = |hv`.
- `out_ch` = first channel with `hv=1` scanning rr, rr+1, … mod NCH.
- `out_data = hold[out_ch]`.
- `out_data`/`out_ch` are don't-care when `out_valid=0`; the implementation drives 0.
- Pop (`out_valid && out_ready`):
  - `hv[out_ch] <= 0`, unless the same channel captures in that cycle, in which case `hv` stays 1 with the new data.
  - `rr <= (out_ch+1) mod NCH`.
- Output is combinational from the registers; `out_valid` never drops without a pop except on reset.

Boundary conditions:
- All channels capture in the same cycle: all legal, and they drain in rr order.
- NCH=1: `out_ch` is constant 0 and `rr` stays 0.
- Reset mid-transfer: all state clears immediately. Pending events and held words are discarded. Sources must be reset together with the block.

## Timing
- Toggle change set up before edge 1 → `s` changes at edge SYNC_STAGES.
- Capture and ack toggle occur at edge SYNC_STAGES+1.
- `out_valid` is high in the following cycle, assuming `hv` was 0.
- Throughput: one word per cycle at the output. Per channel, one word per full req/ack round trip.
- Reset values:
  - `out_valid=0`, `out_data=0`, `out_ch=0`
  - `src_ack_tgl=0`
  - `ovf=0`

## Configuration
- `MUX_SYNC_RR_OVF_EN` defined:
  - `ovf` and `ovf_clr` ports exist.
  - `ovf[c]` sets when `s != sp` while `sp != seen`, i.e. the synchronized request changes again before the previous event was captured, losing a transfer.
  - Set wins over `ovf_clr` in the same cycle.
- Not defined:
  - Ports are absent and no overflow logic is built.
  - A lost toggle is silently merged.

## Test plan
- Ch0 `src_data`=0xA5A50001, toggle `src_req_tgl[0]` 0→1, `out_ready=1` → capture and `src_ack_tgl[0]`=1 at edge 3. Next cycle: `out_valid=1`, `out_ch=0`, `out_data=0xA5A50001`; one cycle later `out_valid=0`.
- Channels 0–3 toggle together with data 0x10..0x13, `out_ready=1` → outputs ch0, ch1, ch2, ch3 on consecutive cycles; `rr` returns to 0.
- `out_ready=0`, ch1 captured with 0x21, then a second ch1 toggle with 0x22 → ack not toggled again and `out_data` stays 0x21. Raise `out_ready` → 0x21 pops; 0x22 is captured in the same cycle, ack toggles, and 0x22 is presented next.
- With the macro defined: hold ch2 full, toggle `src_req_tgl[2]` twice two cycles apart → `ovf[2]=1`. `ovf_clr` pulse clears it. A new overflow in the same cycle as `ovf_clr` leaves `ovf[2]=1`.
- Assert `rst` asynchronously with `hv` set on ch1 and ch3 → `out_valid`, `src_ack_tgl` and `ovf` go to 0 before the next edge. After release, no stale word appears.
- NCH=1, SYNC_STAGES=3 build: toggle with 0xDEADBEEF → `out_valid` one cycle after edge 4, with `out_ch=0`.
